channel_packer: RTL and testbench

//  Packs samples from a variable set of enabled input channels into fixed-width output words.

---
 rtl/channel_packer.sv | 141 ++++++++++++++
 tb/tb_channel_packer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/channel_packer.sv
// Packs the enabled channels of each accepted sample, oldest first, into fixed-width output
// words. Supports back-pressure, flush with zero padding, and sticky overflow reporting.
module channel_packer #(
    parameter int CHANNELS = 4,
    parameter int CH_W     = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cfg_stb_i,
    input  logic [CHANNELS-1:0]      cfg_i,
    input  logic                     stb_i,
    input  logic [CHANNELS*CH_W-1:0] d_i,
    input  logic                     flush_i,
    input  logic                     rdy_i,
    output logic                     stb_o,
    output logic [CHANNELS*CH_W-1:0] q_o,
    output logic                     busy_o,
    output logic                     ovf_o
);
    localparam int SLOTS = 2 * CHANNELS;
    localparam int FW    = $clog2(SLOTS + 1);
    localparam int PW    = FW + 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                         state_q, state_d;
    logic [CHANNELS-1:0]            mask_q, mask_d;
    logic [FW-1:0]                  fill_q, fill_d;
    logic [SLOTS-1:0][CH_W-1:0]     acc_q, acc_d;
    logic [CHANNELS-1:0][CH_W-1:0]  q_q, q_d;
    logic                           stb_q, stb_d;
    logic                           ovf_q, ovf_d;

    logic [PW-1:0]                  k, fill_sum, fill_nxt, pos;
    logic                           slot_free, accept;
    logic [SLOTS-1:0][CH_W-1:0]     acc_ins, acc_sh;
    logic [CHANNELS-1:0][CH_W-1:0]  q_part;

    always_comb begin
        k = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            k = k + PW'(mask_q[c]);
        end
    end

    assign fill_sum  = PW'(fill_q) + k;
    assign slot_free = !stb_q || rdy_i;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        fill_d   = fill_q;
        acc_d    = acc_q;
        q_d      = q_q;
        stb_d    = stb_q && !rdy_i;
        ovf_d    = ovf_q;
        accept   = (state_q == RUN) && stb_i && (mask_q != '0) && (fill_sum <= PW'(SLOTS));
        fill_nxt = accept ? fill_sum : PW'(fill_q);
        acc_ins  = acc_q;
        acc_sh   = '0;
        q_part   = '0;

        // Enabled channels land in ascending index order starting at the current fill level.
        pos = PW'(fill_q);
        for (int c = 0; c < CHANNELS; c++) begin
            if (accept && mask_q[c]) begin
                for (int s = 0; s < SLOTS; s++) begin
                    if (pos == PW'(s)) acc_ins[s] = d_i[c*CH_W +: CH_W];
                end
                pos = pos + 1'b1;
            end
        end
        for (int s = 0; s < CHANNELS; s++) begin
            acc_sh[s] = acc_ins[s+CHANNELS];
            q_part[s] = (PW'(s) < PW'(fill_q)) ? acc_q[s] : '0;
        end

        if (cfg_stb_i) begin
            mask_d  = cfg_i;
            fill_d  = '0;
            acc_d   = '0;
            ovf_d   = 1'b0;
            stb_d   = 1'b0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (stb_i && (mask_q != '0) && !accept) ovf_d = 1'b1;
            if ((fill_nxt >= PW'(CHANNELS)) && slot_free) begin
                q_d    = acc_ins[CHANNELS-1:0];
                stb_d  = 1'b1;
                acc_d  = acc_sh;
                fill_d = FW'(fill_nxt - PW'(CHANNELS));
            end else begin
                acc_d  = acc_ins;
                fill_d = FW'(fill_nxt);
            end
            if (flush_i && (fill_nxt != '0)) state_d = FLUSH;
        end else begin
            if (stb_i) ovf_d = 1'b1;
            if ((PW'(fill_q) >= PW'(CHANNELS)) && slot_free) begin
                q_d    = acc_q[CHANNELS-1:0];
                stb_d  = 1'b1;
                acc_d  = acc_sh;
                fill_d = FW'(PW'(fill_q) - PW'(CHANNELS));
            end else if ((fill_q != '0) && slot_free) begin
                q_d     = q_part;
                stb_d   = 1'b1;
                fill_d  = '0;
                acc_d   = '0;
                state_d = RUN;
            end else if (fill_q == '0) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            mask_q  <= '0;
            fill_q  <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            stb_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            fill_q  <= fill_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            stb_q   <= stb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign stb_o  = stb_q;
    assign q_o    = q_q;
    assign busy_o = (state_q == FLUSH);
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_channel_packer.sv
// Directed testbench for channel_packer (CHANNELS=4, CH_W=8) with hand-computed expected words.
module tb_channel_packer;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_stb_i = 1'b0;
    logic [3:0]  cfg_i = '0;
    logic        stb_i = 1'b0;
    logic [31:0] d_i = '0;
    logic        flush_i = 1'b0;
    logic        rdy_i = 1'b1;
    logic        stb_o;
    logic [31:0] q_o;
    logic        busy_o;
    logic        ovf_o;

    int n_checks = 0;
    int n_fail   = 0;

    channel_packer #(.CHANNELS(4), .CH_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cfg_stb_i(cfg_stb_i), .cfg_i(cfg_i),
        .stb_i(stb_i), .d_i(d_i), .flush_i(flush_i), .rdy_i(rdy_i),
        .stb_o(stb_o), .q_o(q_o), .busy_o(busy_o), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic configure(input logic [3:0] m);
        cfg_stb_i = 1'b1; cfg_i = m;
        tick();
        cfg_stb_i = 1'b0;
    endtask

    task automatic sample(input logic [31:0] d);
        stb_i = 1'b1; d_i = d;
        tick();
        stb_i = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_checks++; if ({stb_o, busy_o, ovf_o} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b, expected 000", {stb_o, busy_o, ovf_o}); end
        n_checks++; if (q_o !== 32'h0) begin n_fail++; $display("FAIL reset_q: got %h, expected 00000000", q_o); end
        #2 rst_i = 1'b0;
        tick();
    endtask

    task automatic test_zero_mask();
        sample(32'hDEADBEEF);
        sample(32'h12345678);
        n_checks++; if ({stb_o, ovf_o} !== 2'b00) begin n_fail++; $display("FAIL mask0_stb_ovf: got %b, expected 00", {stb_o, ovf_o}); end
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL mask0_flush_busy: got %b, expected 0", busy_o); end
    endtask

    task automatic test_basic();
        rdy_i = 1'b1;
        configure(4'b0011);
        sample(32'h0000B1A1);
        n_checks++; if (stb_o !== 1'b0) begin n_fail++; $display("FAIL basic_early_stb: got %b, expected 0", stb_o); end
        sample(32'h0000B2A2);
        n_checks++; if (stb_o !== 1'b1) begin n_fail++; $display("FAIL basic_stb: got %b, expected 1", stb_o); end
        n_checks++; if (q_o !== 32'hB2A2B1A1) begin n_fail++; $display("FAIL basic_q: got %h, expected B2A2B1A1", q_o); end
        tick();
        n_checks++; if (stb_o !== 1'b0) begin n_fail++; $display("FAIL basic_stb_drop: got %b, expected 0", stb_o); end
    endtask

    task automatic test_three_channels();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'hA2C1B1A1; exp_w[1] = 32'hB3A3C2B2; exp_w[2] = 32'hC4B4A4C3;
        rdy_i = 1'b1;
        configure(4'b0111);
        sample(32'h00C1B1A1);
        n_checks++; if (stb_o !== 1'b0) begin n_fail++; $display("FAIL ch3_first_stb: got %b, expected 0", stb_o); end
        for (int n = 2; n <= 4; n++) begin
            sample({8'h00, 8'hC0 + 8'(n), 8'hB0 + 8'(n), 8'hA0 + 8'(n)});
            n_checks++; if ({stb_o, q_o} !== {1'b1, exp_w[n-2]}) begin n_fail++; $display("FAIL ch3_word%0d: got stb=%b q=%h, expected stb=1 q=%h", n - 1, stb_o, q_o, exp_w[n-2]); end
        end
        tick();
        n_checks++; if (stb_o !== 1'b0) begin n_fail++; $display("FAIL ch3_idle: got %b, expected 0", stb_o); end
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ch3_empty_flush: got busy=%b, expected 0", busy_o); end
    endtask

    task automatic test_backpressure();
        configure(4'b0101);
        rdy_i = 1'b0;
        sample(32'h00C100A1);
        sample(32'h00C200A2);
        n_checks++; if ({stb_o, q_o} !== {1'b1, 32'hC2A2C1A1}) begin n_fail++; $display("FAIL bp_word1: got stb=%b q=%h, expected stb=1 q=C2A2C1A1", stb_o, q_o); end
        for (int n = 3; n <= 6; n++) begin
            sample({8'h00, 8'hC0 + 8'(n), 8'h00, 8'hA0 + 8'(n)});
            n_checks++; if ({stb_o, q_o, ovf_o} !== {1'b1, 32'hC2A2C1A1, 1'b0}) begin n_fail++; $display("FAIL bp_hold%0d: got stb=%b q=%h ovf=%b, expected stb=1 q=C2A2C1A1 ovf=0", n, stb_o, q_o, ovf_o); end
        end
        sample(32'h00C700A7);
        n_checks++; if ({q_o, ovf_o} !== {32'hC2A2C1A1, 1'b1}) begin n_fail++; $display("FAIL bp_ovf: got q=%h ovf=%b, expected q=C2A2C1A1 ovf=1", q_o, ovf_o); end
        rdy_i = 1'b1;
        tick();
        n_checks++; if ({stb_o, q_o} !== {1'b1, 32'hC4A4C3A3}) begin n_fail++; $display("FAIL bp_word2: got stb=%b q=%h, expected stb=1 q=C4A4C3A3", stb_o, q_o); end
        tick();
        n_checks++; if ({stb_o, q_o} !== {1'b1, 32'hC6A6C5A5}) begin n_fail++; $display("FAIL bp_word3: got stb=%b q=%h, expected stb=1 q=C6A6C5A5", stb_o, q_o); end
        tick();
        n_checks++; if ({stb_o, ovf_o} !== 2'b01) begin n_fail++; $display("FAIL bp_drain: got stb=%b ovf=%b, expected stb=0 ovf=1", stb_o, ovf_o); end
    endtask

    task automatic test_flush();
        rdy_i = 1'b1;
        configure(4'b0001);
        sample(32'h00000011); sample(32'h00000022); sample(32'h00000033);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        n_checks++; if ({busy_o, stb_o} !== 2'b10) begin n_fail++; $display("FAIL flush_busy: got busy=%b stb=%b, expected busy=1 stb=0", busy_o, stb_o); end
        tick();
        n_checks++; if ({busy_o, stb_o, ovf_o} !== 3'b010) begin n_fail++; $display("FAIL flush_done: got busy=%b stb=%b ovf=%b, expected 0 1 0", busy_o, stb_o, ovf_o); end
        n_checks++; if (q_o !== 32'h00332211) begin n_fail++; $display("FAIL flush_q: got %h, expected 00332211", q_o); end
        sample(32'h00000044);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL flush2_busy: got %b, expected 1", busy_o); end
        sample(32'h00000055);
        n_checks++; if ({busy_o, stb_o, ovf_o, q_o} !== {3'b011, 32'h00000044}) begin n_fail++; $display("FAIL flush2_drop: got busy=%b stb=%b ovf=%b q=%h, expected 0 1 1 00000044", busy_o, stb_o, ovf_o, q_o); end
    endtask

    task automatic test_cfg_priority();
        configure(4'b1111);
        rdy_i = 1'b0;
        sample(32'h04030201); sample(32'h08070605); sample(32'h0C0B0A09); sample(32'h100F0E0D);
        n_checks++; if ({stb_o, ovf_o} !== 2'b11) begin n_fail++; $display("FAIL cfgp_setup: got stb=%b ovf=%b, expected 1 1", stb_o, ovf_o); end
        cfg_stb_i = 1'b1; cfg_i = 4'b0011; stb_i = 1'b1; d_i = 32'hFFFFFFFF;
        tick();
        cfg_stb_i = 1'b0; stb_i = 1'b0;
        n_checks++; if ({stb_o, ovf_o} !== 2'b00) begin n_fail++; $display("FAIL cfgp_clear: got stb=%b ovf=%b, expected 0 0", stb_o, ovf_o); end
        rdy_i = 1'b1;
        sample(32'h0000B1A1);
        n_checks++; if (stb_o !== 1'b0) begin n_fail++; $display("FAIL cfgp_fill0: got %b, expected 0", stb_o); end
        sample(32'h0000B2A2);
        n_checks++; if ({stb_o, q_o} !== {1'b1, 32'hB2A2B1A1}) begin n_fail++; $display("FAIL cfgp_word: got stb=%b q=%h, expected stb=1 q=B2A2B1A1", stb_o, q_o); end
    endtask

    task automatic test_async_reset();
        configure(4'b0011);
        rdy_i = 1'b0;
        sample(32'h0000B1A1); sample(32'h0000B2A2); sample(32'h0000B3A3);
        n_checks++; if (stb_o !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got %b, expected 1", stb_o); end
        #2 rst_i = 1'b1;
        #1;
        n_checks++; if ({stb_o, busy_o, ovf_o, q_o} !== 35'h0) begin n_fail++; $display("FAIL arst_outputs: got stb=%b busy=%b ovf=%b q=%h, expected all 0", stb_o, busy_o, ovf_o, q_o); end
        #2 rst_i = 1'b0;
        test_basic();
    endtask

    initial begin
        test_reset();
        test_zero_mask();
        test_basic();
        test_three_channels();
        test_backpressure();
        test_flush();
        test_cfg_priority();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
